// File: rtl/add_sub_issue.sv
// Command-side initiator for add_sub: FIFO-buffered commands drive the datapath, result is registered.
// Latency: command accepted at edge N -> rsp_valid after edge N+1; one op per cycle when unstalled.
// Backpressure: cmd_ready drops when the FIFO is full; a stalled response freezes capture and pops.
module add_sub_issue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_in1,
  input  logic [WIDTH-1:0] cmd_in2,
  input  logic [1:0]       cmd_flag,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_flag,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_flag,
  output logic [31:0]      ops_done
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] fifo_in1  [DEPTH];
  logic [WIDTH-1:0] fifo_in2  [DEPTH];
  logic [1:0]       fifo_flag [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic not_empty;
  logic push;
  logic capture;
  logic rsp_fire;

  assign not_empty = (count != '0);
  // Readiness depends on occupancy only; a same-cycle pop does not free a slot early.
  assign cmd_ready = !rst && (count < CNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign capture   = not_empty && (!rsp_valid || rsp_ready);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Present the FIFO head to the datapath, zeros when nothing is buffered.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_flag = '0;
    if (not_empty) begin
      alu_in1  = fifo_in1[rd_ptr];
      alu_in2  = fifo_in2[rd_ptr];
      alu_flag = fifo_flag[rd_ptr];
    end
  end

  // Command storage; entries are only observed through the head mux once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_in1[wr_ptr]  <= cmd_in1;
      fifo_in2[wr_ptr]  <= cmd_in2;
      fifo_flag[wr_ptr] <= cmd_flag;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (capture) rd_ptr <= rd_ptr + 1'b1;
      case ({push, capture})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result register: load on capture, clear valid on a handshake with nothing new behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_flag  <= alu_flag;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-response counter, wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_fire) begin
      ops_done <= ops_done + 32'd1;
    end
  end

endmodule
